// File: rtl/mode_counter_pkg.sv
// Shared definitions for the mode_counter block: terminal-action encodings.
package mode_counter_pkg;

    // Terminal action selected by the 2-bit mode input; 2'b11 is reserved
    // and behaves as MODE_WRAP.
    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_ONESHOT = 2'b01;
    localparam logic [1:0] MODE_RELOAD  = 2'b10;

endpackage

// File: rtl/tick_prescaler.sv
// Enable-gated prescaler: emits one tick every presc+1 enabled cycles.
module tick_prescaler #(
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          clr,
    input  logic [PW-1:0] presc,
    output logic          tick
);

    logic [PW-1:0] pcnt_q;
    logic [PW-1:0] pcnt_d;

    // The tick is a same-cycle strobe consumed by the counter, never a block output.
    assign tick = en && (pcnt_q == presc);

    // Next prescale count: clear wins, a match restarts, otherwise advance when
    // enabled. If presc is lowered below pcnt the count runs on, wraps through
    // zero and ticks on its next match.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        pcnt_d = pcnt_q;
        if (clr) begin
            pcnt_d = '0;
        end else if (tick) begin
            pcnt_d = '0;
        end else if (en) begin
            pcnt_d = pcnt_q + 1'b1;
        end
    end

    // Prescale count register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/tt_um_mode_counter.sv
// Tiny Tapeout wrapper: 8-bit counter with 4-bit prescaler, count on uo_out.
// ui_in: [0] en, [1] load, [2] dir, [4:3] mode, [5] clr_ovf, [7:6] presc[1:0].
// uio_in supplies both load_val and limit; the bidirectional pins are inputs only.
module tt_um_mode_counter (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    logic tc;
    logic ovf;
    logic done;
    logic unused_ok;

    mode_counter #(
        .WIDTH(8),
        .PW   (4)
    ) u_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (ui_in[0]),
        .load    (ui_in[1]),
        .load_val(uio_in),
        .dir     (ui_in[2]),
        .mode    (ui_in[4:3]),
        .limit   (uio_in),
        .presc   ({2'b00, ui_in[7:6]}),
        .clr_ovf (ui_in[5]),
        .count   (uo_out),
        .tc      (tc),
        .ovf     (ovf),
        .done    (done)
    );

    assign uio_out   = 8'h00;
    assign uio_oe    = 8'h00;
    assign unused_ok = &{1'b0, ena, tc, ovf, done};

endmodule

// File: rtl/mode_counter.sv
// Prescaled up/down counter with WRAP, ONESHOT and RELOAD terminal actions.
module mode_counter
    import mode_counter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int PW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] limit,
    input  logic [PW-1:0]    presc,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf,
    output logic             done
);

    logic             tick;
    logic             term;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    // A load also restarts the prescale period.
    tick_prescaler #(
        .PW(PW)
    ) u_presc (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .clr  (load),
        .presc(presc),
        .tick (tick)
    );

    // Next state: load beats tick; a frozen ONESHOT ignores ticks entirely.
    always_comb begin
        term    = dir ? (count_q >= limit) : (count_q == '0);
        count_d = count_q;
        tc_d    = 1'b0;
        done_d  = done_q;
        // The set below overrides this clear, so a same-cycle set wins.
        ovf_d   = clr_ovf ? 1'b0 : ovf_q;

        if (load) begin
            count_d = load_val;
            done_d  = 1'b0;
        end else if (tick && !done_q) begin
            if (term) begin
                tc_d  = 1'b1;
                ovf_d = 1'b1;
                case (mode)
                    MODE_ONESHOT: done_d  = 1'b1;
                    MODE_RELOAD:  count_d = load_val;
                    default:      count_d = dir ? '0 : limit;
                endcase
            end else if (dir) begin
                count_d = count_q + 1'b1;
            end else begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Counter state; every output comes straight from these flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign ovf   = ovf_q;
    assign done  = done_q;

endmodule

// File: tb/tb_mode_counter.sv
// Self-checking bench for mode_counter: directed scenarios plus random stimulus
// against a behavioural model.
module tb_mode_counter;

    localparam int W = 8;
    localparam int P = 4;

    logic         clk;
    logic         rst_n;
    logic         en, load, dir, clr_ovf;
    logic [W-1:0] load_val, limit;
    logic [1:0]   mode;
    logic [P-1:0] presc;
    logic [W-1:0] count;
    logic         tc, ovf, done;

    logic         en16, load16;
    logic [15:0]  load_val16, limit16, count16;
    logic         tc16, ovf16, done16;

    logic [7:0]   ui_in, uio_in, uo_out, uio_out, uio_oe;

    int n_vec;
    int n_err;

    // Reference model state.
    int m_count;
    int m_pcnt;
    bit m_tc, m_ovf, m_done;

    mode_counter #(.WIDTH(W), .PW(P)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_val(load_val),
        .dir(dir), .mode(mode), .limit(limit), .presc(presc), .clr_ovf(clr_ovf),
        .count(count), .tc(tc), .ovf(ovf), .done(done)
    );

    mode_counter #(.WIDTH(16), .PW(2)) dut16 (
        .clk(clk), .rst_n(rst_n), .en(en16), .load(load16), .load_val(load_val16),
        .dir(1'b1), .mode(2'b00), .limit(limit16), .presc(2'b00), .clr_ovf(1'b0),
        .count(count16), .tc(tc16), .ovf(ovf16), .done(done16)
    );

    tt_um_mode_counter dut_tt (
        .ui_in(ui_in), .uo_out(uo_out), .uio_in(uio_in), .uio_out(uio_out),
        .uio_oe(uio_oe), .ena(1'b1), .clk(clk), .rst_n(rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_count = 0;
        m_pcnt  = 0;
        m_tc    = 0;
        m_ovf   = 0;
        m_done  = 0;
    endtask

    // One rising edge of the specified behaviour, from the inputs now applied.
    task automatic model_edge();
        bit tick;
        bit term;
        tick = en && (m_pcnt == int'(presc));
        term = dir ? (m_count >= int'(limit)) : (m_count == 0);
        m_tc = 0;
        if (clr_ovf) m_ovf = 0;
        if (load) begin
            m_count = int'(load_val);
            m_pcnt  = 0;
            m_done  = 0;
        end else begin
            if (en) m_pcnt = tick ? 0 : (m_pcnt + 1) % (1 << P);
            if (tick && !m_done) begin
                if (term) begin
                    m_tc  = 1;
                    m_ovf = 1;
                    if (mode == 2'b01)      m_done  = 1;
                    else if (mode == 2'b10) m_count = int'(load_val);
                    else                    m_count = dir ? 0 : int'(limit);
                end else if (dir) begin
                    m_count = (m_count + 1) % (1 << W);
                end else begin
                    m_count = (m_count - 1 + (1 << W)) % (1 << W);
                end
            end
        end
    endtask

    task automatic compare_model();
        check("count", count, m_count);
        check("tc", tc, m_tc);
        check("ovf", ovf, m_ovf);
        check("done", done, m_done);
    endtask

    // Inputs are applied at the falling edge; outputs are sampled at the next one.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_model();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_q[$];
        int en_seq[4];
        int exp_cnt[4];

        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        en = 0; load = 0; dir = 1; clr_ovf = 0; mode = 2'b00;
        load_val = '0; limit = '0; presc = '0;
        en16 = 0; load16 = 0; load_val16 = '0; limit16 = '0;
        ui_in = '0; uio_in = '0;
        model_reset();

        // Reset state.
        @(negedge clk);
        check("rst_count", count, 0);
        check("rst_tc", tc, 0);
        check("rst_ovf", ovf, 0);
        check("rst_done", done, 0);

        // WRAP up, limit 5, presc 0.
        limit = 8'd5; en = 1; rst_n = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            cycle();
            check("wrap_up_count", count, i);
            check("wrap_up_tc", tc, 0);
        end
        cycle();
        check("wrap_up_to0", count, 0);
        check("wrap_up_tc_pulse", tc, 1);
        cycle();
        check("wrap_up_tc_single", tc, 0);

        // WRAP down from 3 with limit 9; clear old ovf during the load.
        load = 1; load_val = 8'd3; clr_ovf = 1;
        cycle();
        check("wrap_dn_load", count, 3);
        check("wrap_dn_ovf_clr", ovf, 0);
        load = 0; clr_ovf = 0; dir = 0; limit = 8'd9;
        exp_q = '{2, 1, 0, 9, 8};
        foreach (exp_q[i]) begin
            cycle();
            check("wrap_dn_count", count, exp_q[i]);
            check("wrap_dn_ovf", ovf, (i >= 3) ? 1 : 0);
        end
        clr_ovf = 1;
        cycle();
        check("clr_ovf", ovf, 0);
        clr_ovf = 0;

        // Prescaler 2 with en pattern 1,1,0,1.
        load = 1; load_val = 8'd0; dir = 1; limit = 8'd200; presc = 4'd2;
        cycle();
        load = 0;
        en_seq  = '{1, 1, 0, 1};
        exp_cnt = '{0, 0, 0, 1};
        foreach (en_seq[i]) begin
            en = en_seq[i][0];
            cycle();
            check("presc_count", count, exp_cnt[i]);
        end
        en = 1;

        // ONESHOT up, limit 3.
        load = 1; load_val = 8'd0; presc = 4'd0; mode = 2'b01; limit = 8'd3;
        cycle();
        load = 0;
        for (int i = 1; i <= 3; i++) cycle();
        check("os_at_limit", count, 3);
        cycle();
        check("os_hold", count, 3);
        check("os_done", done, 1);
        check("os_tc", tc, 1);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("os_frozen_count", count, 3);
            check("os_frozen_tc", tc, 0);
        end
        load = 1; load_val = 8'd0;
        cycle();
        check("os_reload_done", done, 0);
        load = 0;
        cycle();
        check("os_resume", count, 1);

        // RELOAD up, load_val 10, limit 12.
        mode = 2'b10; load = 1; load_val = 8'd10; limit = 8'd12;
        cycle();
        load = 0;
        exp_q = '{11, 12, 10, 11, 12};
        foreach (exp_q[i]) begin
            cycle();
            check("reload_count", count, exp_q[i]);
        end
        load = 1; load_val = 8'd5;
        cycle();
        check("load_over_term_count", count, 5);
        check("load_over_term_tc", tc, 0);
        load = 0;

        // Asynchronous reset mid-count at 7.
        mode = 2'b00; limit = 8'd20; load = 1; load_val = 8'd0;
        cycle();
        load = 0;
        for (int i = 0; i < 7; i++) cycle();
        check("pre_rst_count", count, 7);
        check("pre_rst_ovf", ovf, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_count", count, 0);
        check("async_rst_ovf", ovf, 0);
        check("async_rst_tc", tc, 0);
        check("async_rst_done", done, 0);
        model_reset();
        presc = 4'd3;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("post_rst_wait", count, 0);
        end
        cycle();
        check("post_rst_first_tick", count, 1);

        // Random stimulus against the model.
        for (int n = 0; n < 400; n++) begin
            int r;
            en      = ($urandom_range(0, 3) != 0);
            load    = ($urandom_range(0, 19) == 0);
            clr_ovf = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) dir = ~dir;
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                r = $urandom_range(0, 7);
                if (r == 0)      limit = 8'd0;
                else if (r == 1) limit = 8'd255;
                else             limit = 8'($urandom_range(1, 15));
            end
            load_val = 8'($urandom_range(0, 20));
            if ($urandom_range(0, 15) == 0) presc = 4'($urandom_range(0, 15));
            else if ($urandom_range(0, 15) == 0) presc = 4'($urandom_range(0, 3));
            cycle();
        end

        // 16-bit instance wraps from 0xFFFF with limit 0xFFFF.
        en = 0; load = 0; clr_ovf = 0;
        en16 = 1; load16 = 1; load_val16 = 16'hFFFD; limit16 = 16'hFFFF;
        cycle();
        check("w16_load", count16, 32'hFFFD);
        load16 = 0;
        cycle();
        check("w16_fffe", count16, 32'hFFFE);
        cycle();
        check("w16_ffff", count16, 32'hFFFF);
        check("w16_no_tc", tc16, 0);
        cycle();
        check("w16_wrap", count16, 0);
        check("w16_tc", tc16, 1);
        check("w16_ovf", ovf16, 1);
        check("w16_done", done16, 0);

        // Tiny Tapeout wrapper: en, dir up, WRAP, limit 3.
        ui_in = 8'b0000_0101; uio_in = 8'd3;
        exp_q = '{1, 2, 3, 0, 1};
        foreach (exp_q[i]) begin
            cycle();
            check("tt_uo_out", uo_out, exp_q[i]);
        end
        check("tt_uio_oe", uio_oe, 0);
        check("tt_uio_out", uio_out, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
